// File: rtl/mips_pkg.sv
// mips_pkg: shared control bundle and register constants for the MIPS pipeline
package mips_pkg;
  localparam logic [4:0] REG_RA   = 5'd31;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic       reg_write;
    logic       is_signed;
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       jmp_link;
    logic       jmp_source;
    logic [1:0] alu_sel;
    logic [5:0] alu_code;
    logic [5:0] branch_code;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use compare between the load in EX and the instruction in ID
module hazard_detect
  import mips_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_wreg,
  output logic       hazard
);
  assign hazard = id_valid & ex_valid & ex_mem_read & (ex_wreg != REG_ZERO) &
                  ((ex_wreg == id_rs) | (ex_wreg == id_rt));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble, stall hold and flush; ID_EX_PERF_EN adds saturating stall/bubble/flush counters
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  ctrl_t             id_ctrl,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              ex_valid,
  output ctrl_t             ex_ctrl,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_wreg,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic              id_stall
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);
  logic              hazard, kill, load;
  logic [4:0]        dest;
  logic              ex_valid_d, ex_valid_q;
  ctrl_t             ex_ctrl_d, ex_ctrl_q;
  logic [4:0]        ex_rs_d, ex_rs_q, ex_rt_d, ex_rt_q, ex_wreg_d, ex_wreg_q;
  logic [DATA_W-1:0] ex_rs_data_d, ex_rs_data_q, ex_rt_data_d, ex_rt_data_q;
  logic [DATA_W-1:0] ex_imm_d, ex_imm_q, ex_pc_d, ex_pc_q;

  // A zero-width counter would be meaningless even when counters are compiled out
  if (CNT_W < 1) begin : g_cnt_w_invalid
  end

  hazard_detect u_hazard (
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_valid   (ex_valid_q),
    .ex_mem_read(ex_ctrl_q.mem_read),
    .ex_wreg    (ex_wreg_q),
    .hazard     (hazard)
  );

  assign id_stall = ex_stall | hazard;

  // Next-state selection: flush beats stall beats bubble beats load; data only moves on load
  always_comb begin
    dest         = id_ctrl.jmp_link ? REG_RA : id_ctrl.reg_dst ? id_rd : id_rt;
    kill         = flush | (~ex_stall & hazard);
    load         = ~flush & ~ex_stall & ~hazard;
    ex_valid_d   = kill ? 1'b0 : load ? id_valid : ex_valid_q;
    ex_ctrl_d    = kill ? CTRL_NOP : load ? (id_valid ? id_ctrl : CTRL_NOP) : ex_ctrl_q;
    ex_rs_d      = load ? id_rs : ex_rs_q;
    ex_rt_d      = load ? id_rt : ex_rt_q;
    ex_wreg_d    = load ? dest : ex_wreg_q;
    ex_rs_data_d = load ? id_rs_data : ex_rs_data_q;
    ex_rt_data_d = load ? id_rt_data : ex_rt_data_q;
    ex_imm_d     = load ? id_imm : ex_imm_q;
    ex_pc_d      = load ? id_pc : ex_pc_q;
  end

  // ID/EX register bank
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= CTRL_NOP;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_wreg_q    <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_pc_q      <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_wreg_q    <= ex_wreg_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_pc_q      <= ex_pc_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_wreg    = ex_wreg_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_pc      = ex_pc_q;

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, bubble_cnt_d, bubble_cnt_q, flush_cnt_d, flush_cnt_q;

  // Saturating event counters; a bubble is only counted when it is actually inserted
  always_comb begin
    stall_cnt_d  = (ex_stall & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    bubble_cnt_d = (~flush & ~ex_stall & hazard & ~&bubble_cnt_q) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
    flush_cnt_d  = (flush & ~&flush_cnt_q) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven directed check of the ID/EX register, hazard bubble, stall, flush and reset
module tb_id_ex_stage;
  import mips_pkg::*;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid, ex_stall, flush;
  ctrl_t         id_ctrl, ex_ctrl;
  logic [4:0]    id_rs, id_rt, id_rd, ex_rs, ex_rt, ex_wreg;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
  logic          ex_valid, id_stall;
`ifdef ID_EX_PERF_EN
  logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc(id_pc),
    .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .id_stall(id_stall)
`ifdef ID_EX_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    logic       fl, st, v;
    ctrl_t      c;
    logic [4:0] rs, rt, rd;
    logic [31:0] pc;
    logic       e_stall, e_v;
    ctrl_t      e_c;
    logic [4:0] e_wreg;
    logic [31:0] e_pc;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  ctrl_t c_add, c_lw, c_jal;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic st, input logic v, input ctrl_t c,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] pc);
    flush = fl; ex_stall = st; id_valid = v; id_ctrl = c;
    id_rs = rs; id_rt = rt; id_rd = rd; id_pc = pc;
    id_rs_data = pc ^ 32'h1111_0000;
    id_rt_data = pc ^ 32'h2222_0000;
    id_imm     = pc ^ 32'h3333_0000;
  endtask

  function automatic vec_t row(input logic fl, input logic st, input logic v, input ctrl_t c,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic [31:0] pc, input logic es, input logic ev,
                               input ctrl_t ec, input logic [4:0] ew, input logic [31:0] ep);
    vec_t r;
    r.fl = fl; r.st = st; r.v = v; r.c = c; r.rs = rs; r.rt = rt; r.rd = rd; r.pc = pc;
    r.e_stall = es; r.e_v = ev; r.e_c = ec; r.e_wreg = ew; r.e_pc = ep;
    return r;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " ex_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, " ex_ctrl"}, 32'(ex_ctrl), 32'd0);
    chk({tag, " ex_wreg"}, 32'(ex_wreg), 32'd0);
    chk({tag, " ex_rs"}, 32'(ex_rs), 32'd0);
    chk({tag, " ex_rt"}, 32'(ex_rt), 32'd0);
    chk({tag, " ex_pc"}, ex_pc, 32'd0);
    chk({tag, " ex_rs_data"}, ex_rs_data, 32'd0);
    chk({tag, " ex_rt_data"}, ex_rt_data, 32'd0);
    chk({tag, " ex_imm"}, ex_imm, 32'd0);
  endtask

  initial begin
    c_add = '0; c_add.reg_write = 1'b1; c_add.reg_dst = 1'b1; c_add.alu_sel = 2'd2; c_add.alu_code = 6'h20;
    c_lw  = '0; c_lw.reg_write = 1'b1; c_lw.mem_read = 1'b1; c_lw.mem_to_reg = 1'b1; c_lw.is_signed = 1'b1; c_lw.alu_code = 6'h20;
    c_jal = '0; c_jal.reg_write = 1'b1; c_jal.jump = 1'b1; c_jal.jmp_link = 1'b1;
    //               fl st v  ctrl   rs  rt  rd  pc        stall v  ectrl   wreg pc
    tbl.push_back(row(0, 0, 1, c_add, 1,  2,  3,  32'h04,  0, 1, c_add, 3,  32'h04));
    tbl.push_back(row(0, 0, 1, c_lw,  1,  5,  0,  32'h08,  0, 1, c_lw,  5,  32'h08));
    tbl.push_back(row(0, 0, 1, c_add, 5,  2,  6,  32'h0C,  1, 0, '0,    5,  32'h08));
    tbl.push_back(row(0, 0, 1, c_add, 5,  2,  6,  32'h0C,  0, 1, c_add, 6,  32'h0C));
    tbl.push_back(row(0, 0, 1, c_lw,  1,  0,  0,  32'h10,  0, 1, c_lw,  0,  32'h10));
    tbl.push_back(row(0, 0, 1, c_add, 0,  0,  7,  32'h14,  0, 1, c_add, 7,  32'h14));
    tbl.push_back(row(0, 0, 1, c_jal, 0,  7,  0,  32'h18,  0, 1, c_jal, 31, 32'h18));
    tbl.push_back(row(0, 0, 1, c_add, 3,  4,  9,  32'h1C,  0, 1, c_add, 9,  32'h1C));
    tbl.push_back(row(0, 1, 1, c_add, 1,  2,  10, 32'h40,  1, 1, c_add, 9,  32'h1C));
    tbl.push_back(row(0, 1, 1, c_add, 1,  2,  10, 32'h40,  1, 1, c_add, 9,  32'h1C));
    tbl.push_back(row(0, 1, 1, c_add, 1,  2,  10, 32'h40,  1, 1, c_add, 9,  32'h1C));
    tbl.push_back(row(0, 0, 1, c_add, 1,  2,  10, 32'h40,  0, 1, c_add, 10, 32'h40));
    tbl.push_back(row(1, 1, 1, c_lw,  1,  11, 0,  32'h44,  1, 0, '0,    10, 32'h40));
    tbl.push_back(row(0, 0, 0, c_lw,  1,  12, 0,  32'h48,  0, 0, '0,    12, 32'h48));
    tbl.push_back(row(0, 0, 1, c_lw,  1,  13, 0,  32'h4C,  0, 1, c_lw,  13, 32'h4C));
    tbl.push_back(row(1, 0, 1, c_add, 2,  13, 14, 32'h50,  1, 0, '0,    13, 32'h4C));
    tbl.push_back(row(0, 0, 1, c_add, 2,  13, 14, 32'h50,  0, 1, c_add, 14, 32'h50));
    tbl.push_back(row(0, 0, 1, c_lw,  1,  15, 0,  32'h54,  0, 1, c_lw,  15, 32'h54));
    tbl.push_back(row(0, 1, 1, c_add, 15, 15, 16, 32'h58,  1, 1, c_lw,  15, 32'h54));
    tbl.push_back(row(0, 0, 1, c_add, 15, 15, 16, 32'h58,  1, 0, '0,    15, 32'h54));
    tbl.push_back(row(0, 0, 1, c_add, 15, 15, 16, 32'h58,  0, 1, c_add, 16, 32'h58));
    tbl.push_back(row(0, 0, 1, c_lw,  1,  17, 0,  32'h5C,  0, 1, c_lw,  17, 32'h5C));
    tbl.push_back(row(0, 0, 0, c_add, 17, 2,  18, 32'h60,  0, 0, '0,    18, 32'h60));

    drive(0, 0, 0, '0, 0, 0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    chk("reset id_stall", 32'(id_stall), 32'd0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].fl, tbl[i].st, tbl[i].v, tbl[i].c, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].pc);
      #1;
      chk($sformatf("row%0d id_stall", i), 32'(id_stall), 32'(tbl[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d ex_valid", i), 32'(ex_valid), 32'(tbl[i].e_v));
      chk($sformatf("row%0d ex_ctrl", i), 32'(ex_ctrl), 32'(tbl[i].e_c));
      chk($sformatf("row%0d ex_wreg", i), 32'(ex_wreg), 32'(tbl[i].e_wreg));
      chk($sformatf("row%0d ex_pc", i), ex_pc, tbl[i].e_pc);
      if (tbl[i].e_v)
        chk($sformatf("row%0d ex_rs_data", i), ex_rs_data, tbl[i].e_pc ^ 32'h1111_0000);
      @(negedge clk);
    end

    drive(0, 0, 1, c_add, 1, 2, 20, 32'h70);
    @(posedge clk);
    #1;
    chk("pre-reset ex_imm", ex_imm, 32'h3333_0070);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async reset");
    drive(0, 1, 1, c_add, 20, 2, 21, 32'h74);
    #1;
    chk("reset ex_stall id_stall", 32'(id_stall), 32'd1);
    drive(0, 0, 1, c_add, 20, 2, 21, 32'h74);
    #1;
    chk("reset no hazard id_stall", 32'(id_stall), 32'd0);
    @(negedge clk);
    chk("reset held ex_valid", 32'(ex_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("release id_stall", 32'(id_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("release ex_valid", 32'(ex_valid), 32'd1);
    chk("release ex_wreg", 32'(ex_wreg), 32'd21);
    chk("release ex_pc", ex_pc, 32'h74);

`ifdef ID_EX_PERF_EN
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("cnt reset stall", 32'(stall_cnt), 32'd0);
    chk("cnt reset bubble", 32'(bubble_cnt), 32'd0);
    chk("cnt reset flush", 32'(flush_cnt), 32'd0);
    rst = 1'b1;
    drive(0, 1, 0, '0, 0, 0, 0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cnt stall 3", 32'(stall_cnt), 32'd3);
    drive(1, 0, 0, '0, 0, 0, 0, 32'h0);
    @(negedge clk);
    chk("cnt flush 1", 32'(flush_cnt), 32'd1);
    drive(0, 0, 1, c_lw, 1, 5, 0, 32'h80);
    @(negedge clk);
    drive(0, 0, 1, c_add, 5, 2, 6, 32'h84);
    @(negedge clk);
    chk("cnt bubble 1", 32'(bubble_cnt), 32'd1);
    drive(0, 1, 0, '0, 0, 0, 0, 32'h0);
    repeat (65532) @(posedge clk);
    @(negedge clk);
    chk("cnt stall max", 32'(stall_cnt), 32'hFFFF);
    @(negedge clk);
    chk("cnt stall saturate", 32'(stall_cnt), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
